usb_tx: RTL

// - USB full-speed packet transmitter: the transmit-side counterpart of usb_rx.
// - Sends handshake (ACK/NAK/STALL) and DATA0 packets on dp_out/dm_out.
// - Framing: SYNC, PID, payload, bit-stuffing, NRZI encoding, EOP.
// - Payload bytes are popped from data_buffer through tx_packet_data/get_tx_packet_data.

---
 rtl/usb_tx.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - USB full-speed handshake/DATA0 transmitter; optional CRC16 stage enabled by USB_TX_CRC16_EN
module usb_tx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);
    localparam int            TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
`ifdef USB_TX_CRC16_EN
        S_CRC,
`endif
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    // State registers describe the bit currently on the line; the timer counts within it.
    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    pid, pid_n;
    logic          is_data, is_data_n;
    logic          stuff, stuff_n;
    logic [2:0]    ones, ones_n;
    logic          dp, dp_n, dm, dm_n;
    logic          active, active_n, get, get_n, err, err_n;
    logic          boundary, emit, bit_n;
`ifdef USB_TX_CRC16_EN
    logic [15:0]   crc, crc_n, crc_upd;
`endif

    function automatic logic is_stream(input state_t s);
        is_stream = (s == S_SYNC) || (s == S_PID) || (s == S_DATA)
`ifdef USB_TX_CRC16_EN
                    || (s == S_CRC)
`endif
                    ;
    endfunction

`ifdef USB_TX_CRC16_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction
`endif

    // Next-state logic: request decode in IDLE, bit sequencing and stuffing at each bit-timer wrap.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        idx_n     = idx;
        shreg_n   = shreg;
        pid_n     = pid;
        is_data_n = is_data;
        stuff_n   = stuff;
        ones_n    = ones;
        dp_n      = dp;
        dm_n      = dm;
        active_n  = active;
        get_n     = 1'b0;
        err_n     = 1'b0;
        boundary  = 1'b0;
        emit      = 1'b0;
        bit_n     = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_n     = crc;
        crc_upd   = crc;
        if (state == S_DATA && !stuff) begin
            crc_upd = crc_step(crc, shreg[0]);
        end
`endif
        if (state == S_IDLE) begin
            dp_n = 1'b1;
            dm_n = 1'b0;
            if (tx_packet >= 3'd1 && tx_packet <= 3'd4) begin
                state_n   = S_SYNC;
                timer_n   = '0;
                idx_n     = '0;
                shreg_n   = 8'h80;
                stuff_n   = 1'b0;
                ones_n    = '0;
                active_n  = 1'b1;
                is_data_n = (tx_packet == 3'd1);
                emit      = 1'b1;
                case (tx_packet)
                    3'd1:    pid_n = 8'hC3;
                    3'd2:    pid_n = 8'hD2;
                    3'd3:    pid_n = 8'h5A;
                    default: pid_n = 8'h1E;
                endcase
`ifdef USB_TX_CRC16_EN
                crc_n = 16'hFFFF;
`endif
            end else if (tx_packet != 3'd0) begin
                err_n = 1'b1;
            end
        end else if (timer != TMAX) begin
            timer_n = timer + 1'b1;
        end else begin
            timer_n = '0;
            emit    = 1'b1;
`ifdef USB_TX_CRC16_EN
            crc_n = crc_upd;
`endif
            // Six ones just went out: a stuffed zero takes the next bit slot, position is held.
            if (is_stream(state) && !stuff && ones == 3'd6) begin
                stuff_n = 1'b1;
            end else begin
                stuff_n = 1'b0;
                case (state)
                    S_SYNC: begin
                        if (idx != 4'd7) begin
                            idx_n   = idx + 4'd1;
                            shreg_n = shreg >> 1;
                        end else begin
                            state_n = S_PID;
                            idx_n   = '0;
                            shreg_n = pid;
                        end
                    end
                    S_PID, S_DATA: begin
                        if (idx != 4'd7) begin
                            idx_n   = idx + 4'd1;
                            shreg_n = shreg >> 1;
                        end else if (is_data) begin
                            boundary = 1'b1;
                        end else begin
                            state_n = S_EOP_SE0;
                            idx_n   = '0;
                        end
                    end
`ifdef USB_TX_CRC16_EN
                    S_CRC: begin
                        crc_n = {crc[14:0], 1'b0};
                        if (idx != 4'd15) begin
                            idx_n = idx + 4'd1;
                        end else begin
                            state_n = S_EOP_SE0;
                            idx_n   = '0;
                        end
                    end
`endif
                    S_EOP_SE0: begin
                        if (idx == 4'd0) begin
                            idx_n = 4'd1;
                        end else begin
                            state_n = S_EOP_J;
                            idx_n   = '0;
                        end
                    end
                    S_EOP_J: begin
                        state_n  = S_IDLE;
                        active_n = 1'b0;
                    end
                    default: state_n = S_IDLE;
                endcase
                // Payload length is decided byte by byte from the live buffer occupancy.
                if (boundary) begin
                    idx_n = '0;
                    if (buffer_occupancy != 7'd0) begin
                        state_n = S_DATA;
                        shreg_n = tx_packet_data;
                        get_n   = 1'b1;
                    end else begin
`ifdef USB_TX_CRC16_EN
                        state_n = S_CRC;
`else
                        state_n = S_EOP_SE0;
`endif
                    end
                end
            end
        end
        // Line level for a newly presented bit: NRZI in the packet body, fixed levels in EOP/idle.
        if (emit) begin
            if (is_stream(state_n)) begin
                bit_n = stuff_n ? 1'b0 : shreg_n[0];
`ifdef USB_TX_CRC16_EN
                if (state_n == S_CRC && !stuff_n) begin
                    bit_n = ~crc_n[15];
                end
`endif
                ones_n = bit_n ? ones + 3'd1 : 3'd0;
                if (!bit_n) begin
                    dp_n = ~dp;
                    dm_n = ~dm;
                end
            end else if (state_n == S_EOP_SE0) begin
                dp_n = 1'b0;
                dm_n = 1'b0;
            end else begin
                dp_n = 1'b1;
                dm_n = 1'b0;
            end
        end
    end

    // State and output registers with synchronous active-low reset to idle J.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            idx     <= '0;
            shreg   <= '0;
            pid     <= '0;
            is_data <= 1'b0;
            stuff   <= 1'b0;
            ones    <= '0;
            dp      <= 1'b1;
            dm      <= 1'b0;
            active  <= 1'b0;
            get     <= 1'b0;
            err     <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc     <= 16'hFFFF;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            pid     <= pid_n;
            is_data <= is_data_n;
            stuff   <= stuff_n;
            ones    <= ones_n;
            dp      <= dp_n;
            dm      <= dm_n;
            active  <= active_n;
            get     <= get_n;
            err     <= err_n;
`ifdef USB_TX_CRC16_EN
            crc     <= crc_n;
`endif
        end
    end

    assign dp_out             = dp;
    assign dm_out             = dm;
    assign tx_transfer_active = active;
    assign get_tx_packet_data = get;
    assign tx_error           = err;
endmodule
